axi_mem_tester: RTL and testbench

- Synthesizable AXI4 initiator (burst master) that drives the 32-bit mem_axi interface presented to the SDRAM controller, i.e. the requesting end of the memory bus the controller answers.
- Writes a deterministic pattern over a memory region with INCR bursts, reads the region back, compares, and reports error count and first failing address.
- Used for SDRAM bring-up/BIST, muxed onto mem_axi ahead of soc_top.

---
 rtl/axi_mem_tester_pkg.sv | 23 ++
 rtl/axi_mem_tester_cmp.sv | 14 +
 rtl/axi_mem_tester.sv | 194 +++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_tester_pkg.sv
// rtl/axi_mem_tester_pkg.sv - shared states, AXI constants and pattern function for axi_mem_tester
package axi_mem_tester_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_FIN
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Word address (byte address with the two low bits cleared) XOR seed.
    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return (addr & 32'hFFFF_FFFC) ^ seed;
    endfunction

endpackage

// File: rtl/axi_mem_tester_cmp.sv
// rtl/axi_mem_tester_cmp.sv - combinational readback compare of one read beat
module axi_mem_tester_cmp
    import axi_mem_tester_pkg::*;
(
    input  logic [31:0] beat_addr,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic [31:0] seed,
    output logic        miss
);

    assign miss = (rdata != pattern(beat_addr, seed)) || (rresp != RESP_OKAY);

endmodule

// File: rtl/axi_mem_tester.sv
// rtl/axi_mem_tester.sv - AXI4 burst write/readback memory tester
module axi_mem_tester
    import axi_mem_tester_pkg::*;
#(
    parameter int ID_W      = 6,
    parameter int AXI_ID    = 0,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_bursts,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      first_err_addr,
    output logic             proto_err,
    output logic [ID_W-1:0]  m_axi_awid,
    output logic [31:0]      m_axi_awaddr,
    output logic [7:0]       m_axi_awlen,
    output logic [2:0]       m_axi_awsize,
    output logic [1:0]       m_axi_awburst,
    output logic             m_axi_awvalid,
    input  logic             m_axi_awready,
    output logic [31:0]      m_axi_wdata,
    output logic [3:0]       m_axi_wstrb,
    output logic             m_axi_wlast,
    output logic             m_axi_wvalid,
    input  logic             m_axi_wready,
    input  logic [ID_W-1:0]  m_axi_bid,
    input  logic [1:0]       m_axi_bresp,
    input  logic             m_axi_bvalid,
    output logic             m_axi_bready,
    output logic [ID_W-1:0]  m_axi_arid,
    output logic [31:0]      m_axi_araddr,
    output logic [7:0]       m_axi_arlen,
    output logic [2:0]       m_axi_arsize,
    output logic [1:0]       m_axi_arburst,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [ID_W-1:0]  m_axi_rid,
    input  logic [31:0]      m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rlast,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready
);

    localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * 4);
    localparam logic [31:0]     ALIGN_MASK  = ~(BURST_BYTES - 32'd1);
    localparam logic [ID_W-1:0] ID_V        = ID_W'(AXI_ID);
    localparam logic [8:0]      LAST_BEAT   = 9'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [31:0]      base_q, seed_q, cur_addr, beat_addr;
    logic [CNT_W-1:0] nb_q, burst_cnt;
    logic [8:0]       beat;
    logic             err_seen, last_burst, beat_last, rd_miss;

    assign beat_addr  = cur_addr + {21'd0, beat, 2'b00};
    assign last_burst = (burst_cnt == nb_q - CNT_W'(1));
    assign beat_last  = (beat == LAST_BEAT);

    assign m_axi_awid    = ID_V;
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wdata   = pattern(beat_addr, seed_q);
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = beat_last;
    assign m_axi_arid    = ID_V;
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;

    assign busy = (state != S_IDLE) && (state != S_FIN);

    axi_mem_tester_cmp u_cmp (
        .beat_addr (beat_addr),
        .rdata     (m_axi_rdata),
        .rresp     (m_axi_rresp),
        .seed      (seed_q),
        .miss      (rd_miss)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n       = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = (num_bursts == '0) ? S_FIN : S_AW;
            S_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_n = S_W;
            end
            S_W: begin
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && beat_last) state_n = S_B;
            end
            S_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_n = last_burst ? S_AR : S_AW;
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_n = S_R;
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && m_axi_rlast) state_n = last_burst ? S_FIN : S_AR;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q         <= '0;
            seed_q         <= '0;
            nb_q           <= '0;
            cur_addr       <= '0;
            burst_cnt      <= '0;
            beat           <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    base_q         <= base_addr & ALIGN_MASK;
                    cur_addr       <= base_addr & ALIGN_MASK;
                    seed_q         <= seed;
                    nb_q           <= num_bursts;
                    burst_cnt      <= '0;
                    beat           <= '0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    err_seen       <= 1'b0;
                    proto_err      <= 1'b0;
                end
                S_AW, S_AR: beat <= '0;
                S_W: if (m_axi_wready) beat <= beat + 9'd1;
                S_B: if (m_axi_bvalid) begin
                    if (m_axi_bresp != RESP_OKAY && !(&err_count)) err_count <= err_count + CNT_W'(1);
                    if (m_axi_bid != ID_V) proto_err <= 1'b1;
                    if (last_burst) begin
                        cur_addr  <= base_q;
                        burst_cnt <= '0;
                    end else begin
                        cur_addr  <= cur_addr + BURST_BYTES;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                S_R: if (m_axi_rvalid) begin
                    beat <= beat + 9'd1;
                    if (rd_miss) begin
                        if (!(&err_count)) err_count <= err_count + CNT_W'(1);
                        if (!err_seen) begin
                            first_err_addr <= beat_addr;
                            err_seen       <= 1'b1;
                        end
                    end
                    // rlast must coincide with the final beat; the burst still ends on rlast.
                    if ((m_axi_rlast != beat_last) || (m_axi_rid != ID_V)) proto_err <= 1'b1;
                    if (m_axi_rlast && !last_burst) begin
                        cur_addr  <= cur_addr + BURST_BYTES;
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_tester.sv
// tb/tb_axi_mem_tester.sv - scoreboard bench for axi_mem_tester with an AXI slave model
module tb_axi_mem_tester;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_bursts = '0;
    logic [31:0] seed = '0;
    logic        busy, done, proto_err;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic [5:0]  m_axi_awid, m_axi_arid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic [5:0]  m_axi_bid = '0, m_axi_rid = '0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [31:0] m_axi_rdata = '0;

    always #5 clk = ~clk;

    axi_mem_tester dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
        .seed(seed), .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .proto_err(proto_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s);
        return {a[31:2], 2'b00} ^ s;
    endfunction

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    logic [32:0] exp_w_q[$];

    int          stall_pct = 0, bad_b = -1, early_burst = -1;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;
    int          aw_cnt = 0, ar_cnt = 0, b_idx = 0, rb_idx = 0, r_beat = 0;
    logic        b_pend = 0, r_pend = 0, prev_b_hs = 0, prev_r_hs = 0, w_open = 0;
    logic        aw_st = 0, w_st = 0, ar_st = 0;
    logic [31:0] aw_sv, ar_sv, w_sv, w_addr, r_addr, a;
    logic        wl_sv;
    logic [32:0] e;
    logic [31:0] mem [logic [31:0]];

    function automatic logic rdy();
        return ($urandom_range(0, 99) >= stall_pct);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                b_pend = 0; r_pend = 0; prev_b_hs = 0; prev_r_hs = 0;
                aw_st = 0; w_st = 0; ar_st = 0; w_open = 0;
            end else begin
                if (prev_b_hs) begin
                    m_axi_bvalid = 0; b_pend = 0; b_idx++; prev_b_hs = 0;
                end
                if (prev_r_hs) begin
                    m_axi_rvalid = 0; prev_r_hs = 0;
                    if (m_axi_rlast) begin r_pend = 0; rb_idx++; m_axi_rlast = 0; end
                    else r_beat++;
                end
                if (aw_st) begin
                    check_eq("aw_hold_valid", 32'(m_axi_awvalid), 1);
                    check_eq("aw_hold_addr", m_axi_awaddr, aw_sv);
                end
                if (w_st) begin
                    check_eq("w_hold_valid", 32'(m_axi_wvalid), 1);
                    check_eq("w_hold_data", m_axi_wdata, w_sv);
                    check_eq("w_hold_last", 32'(m_axi_wlast), 32'(wl_sv));
                end
                if (ar_st) begin
                    check_eq("ar_hold_valid", 32'(m_axi_arvalid), 1);
                    check_eq("ar_hold_addr", m_axi_araddr, ar_sv);
                end
                m_axi_awready = rdy();
                m_axi_wready  = rdy();
                m_axi_arready = rdy();
                if (b_pend && !m_axi_bvalid) begin
                    m_axi_bvalid = 1; m_axi_bid = '0;
                    m_axi_bresp = (b_idx == bad_b) ? 2'b10 : 2'b00;
                end
                if (r_pend && !m_axi_rvalid && rdy()) begin
                    a = r_addr + 32'(r_beat * 4);
                    m_axi_rvalid = 1; m_axi_rid = '0; m_axi_rresp = 2'b00;
                    m_axi_rdata = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
                    if (corrupt_en && a == corrupt_addr) m_axi_rdata[0] = ~m_axi_rdata[0];
                    m_axi_rlast = (rb_idx == early_burst) ? (r_beat == 7) : (r_beat == 15);
                end
                if (m_axi_wvalid) check_eq("w_after_aw", 32'(w_open), 1);
                aw_st = m_axi_awvalid && !m_axi_awready;
                aw_sv = m_axi_awaddr;
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_cnt++; w_addr = m_axi_awaddr; w_open = 1;
                    check_eq("aw_expected", 32'(exp_aw_q.size() > 0), 1);
                    if (exp_aw_q.size() > 0) check_eq("awaddr", m_axi_awaddr, exp_aw_q.pop_front());
                    check_eq("awlen", 32'(m_axi_awlen), 15);
                end
                w_st = m_axi_wvalid && !m_axi_wready;
                w_sv = m_axi_wdata; wl_sv = m_axi_wlast;
                if (m_axi_wvalid && m_axi_wready) begin
                    check_eq("w_expected", 32'(exp_w_q.size() > 0), 1);
                    if (exp_w_q.size() > 0) begin
                        e = exp_w_q.pop_front();
                        check_eq("wdata", m_axi_wdata, e[31:0]);
                        check_eq("wlast", 32'(m_axi_wlast), 32'(e[32]));
                    end
                    mem[w_addr] = m_axi_wdata;
                    w_addr += 4;
                    if (m_axi_wlast) begin b_pend = 1; w_open = 0; end
                end
                ar_st = m_axi_arvalid && !m_axi_arready;
                ar_sv = m_axi_araddr;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_cnt++; r_pend = 1; r_addr = m_axi_araddr; r_beat = 0;
                    check_eq("ar_expected", 32'(exp_ar_q.size() > 0), 1);
                    if (exp_ar_q.size() > 0) check_eq("araddr", m_axi_araddr, exp_ar_q.pop_front());
                end
                prev_r_hs = m_axi_rvalid && m_axi_rready;
                prev_b_hs = m_axi_bvalid && m_axi_bready;
            end
        end
    end

    task automatic run_test(input string name, input logic [31:0] base, input logic [31:0] exp_base,
                            input int nb, input logic [31:0] sd, input int exp_err,
                            input logic exp_proto, input logic [31:0] exp_first);
        int cyc, aw0, ar0;
        logic [31:0] ba;
        for (int b = 0; b < nb; b++) begin
            ba = exp_base + 32'(b * 64);
            exp_aw_q.push_back(ba);
            exp_ar_q.push_back(ba);
            for (int k = 0; k < 16; k++) exp_w_q.push_back({k == 15, pat(ba + 32'(k * 4), sd)});
        end
        b_idx = 0; rb_idx = 0; aw0 = aw_cnt; ar0 = ar_cnt;
        @(negedge clk);
        base_addr = base; num_bursts = 16'(nb); seed = sd; start = 1;
        @(negedge clk);
        start = 0; cyc = 1;
        if (nb != 0) check_eq({name, "_busy"}, 32'(busy), 1);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({name, "_done"}, 32'(done), 1);
        if (nb == 0) check_eq({name, "_latency_ok"}, 32'(cyc <= 2), 1);
        @(negedge clk);
        check_eq({name, "_done_pulse"}, 32'(done), 0);
        check_eq({name, "_busy_end"}, 32'(busy), 0);
        check_eq({name, "_err_count"}, 32'(err_count), 32'(exp_err));
        check_eq({name, "_proto_err"}, 32'(proto_err), 32'(exp_proto));
        check_eq({name, "_first_err"}, first_err_addr, exp_first);
        check_eq({name, "_aw_count"}, 32'(aw_cnt - aw0), 32'(nb));
        check_eq({name, "_ar_count"}, 32'(ar_cnt - ar0), 32'(nb));
        check_eq({name, "_sb_empty"}, 32'(exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size()), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check_eq("rst_err_count", 32'(err_count), 0);
        check_eq("rst_first_err", first_err_addr, 0);
        check_eq("rst_proto_err", 32'(proto_err), 0);
        check_eq("rst_aw_fields", {16'd0, m_axi_awlen, 1'b0, m_axi_awsize, 2'b0, m_axi_awburst}, 32'h0000_0F21);
        check_eq("rst_ar_fields", {16'd0, m_axi_arlen, 1'b0, m_axi_arsize, 2'b0, m_axi_arburst}, 32'h0000_0F21);
        check_eq("rst_wstrb_ids", {20'd0, m_axi_wstrb, 2'b0, m_axi_awid}, 32'h0000_0F00);
        reset = 0;

        run_test("clean", 32'h0000_1000, 32'h0000_1000, 4, 32'hA5A5_5A5A, 0, 0, 32'h0);

        corrupt_en = 1; corrupt_addr = 32'h0000_1044;
        run_test("corrupt", 32'h0000_1000, 32'h0000_1000, 4, 32'hA5A5_5A5A, 1, 0, 32'h0000_1044);
        corrupt_en = 0;

        stall_pct = 30;
        run_test("stall", 32'h0000_1000, 32'h0000_1000, 4, 32'hA5A5_5A5A, 0, 0, 32'h0);
        stall_pct = 0;

        bad_b = 1;
        run_test("bresp", 32'h0000_1000, 32'h0000_1000, 4, 32'h1234_5678, 1, 0, 32'h0);
        bad_b = -1;

        early_burst = 0;
        run_test("early_rlast", 32'h0000_1000, 32'h0000_1000, 4, 32'h0F0F_F0F0, 0, 1, 32'h0);
        early_burst = -1;

        run_test("zero", 32'h0000_1000, 32'h0000_1000, 0, 32'h0, 0, 0, 32'h0);

        run_test("unaligned", 32'h0000_1007, 32'h0000_1000, 2, 32'hCAFE_F00D, 0, 0, 32'h0);

        run_test("wrap", 32'hFFFF_FFC0, 32'hFFFF_FFC0, 2, 32'h5555_AAAA, 0, 0, 32'h0);

        // Reset in the middle of a write burst.
        for (int b = 0; b < 4; b++) begin
            exp_aw_q.push_back(32'h0000_2000 + 32'(b * 64));
            for (int k = 0; k < 16; k++) exp_w_q.push_back({k == 15, pat(32'h0000_2000 + 32'(b * 64 + k * 4), 32'h1)});
        end
        @(negedge clk);
        base_addr = 32'h0000_2000; num_bursts = 16'd4; seed = 32'h1; start = 1;
        @(negedge clk);
        start = 0; cyc = 0;
        while (!m_axi_wvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rstw_reached_w", 32'(m_axi_wvalid), 1);
        reset = 1;
        @(negedge clk);
        check_eq("rstw_wvalid", 32'(m_axi_wvalid), 0);
        check_eq("rstw_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 0;
        exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();

        stall_pct = 30;
        run_test("after_reset", 32'h0000_3000, 32'h0000_3000, 3, 32'h8765_4321, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
